// File: rtl/redux_stream_if.sv
// Pixel stream bundle for the 2x2 reducer: input handshake, output handshake
// with row/frame markers, mode select and frame-in-progress flag.
interface redux_stream_if #(
  parameter int PIX_W = 8
);
  logic [1:0]       mode;
  logic [PIX_W-1:0] in_pix;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] out_pix;
  logic             out_valid;
  logic             out_ready;
  logic             out_eol;
  logic             out_eof;
  logic             busy;

  modport master (
    output mode, in_pix, in_valid, out_ready,
    input  in_ready, out_pix, out_valid, out_eol, out_eof, busy
  );

  modport slave (
    input  mode, in_pix, in_valid, out_ready,
    output in_ready, out_pix, out_valid, out_eol, out_eof, busy
  );
endinterface

// File: rtl/redux_stream.sv
// Streaming 2x2 image reducer: raster pixels in, one max/min/mean/decimated
// pixel out per 2x2 block, using a half-width line buffer of pair values.
module redux_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          clk,
  input  logic          rst,
  redux_stream_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int BW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] p0;
  logic [PIX_W:0]   linebuf [IMG_W/2];

  logic             accept;
  logic             at_first;
  logic             at_last_col;
  logic             at_last;
  logic [BW-1:0]    bidx;
  logic [PIX_W:0]   pair;
  logic [PIX_W:0]   bufv;
  logic [PIX_W+1:0] sum;
  logic [PIX_W-1:0] res;

  assign bus.in_ready = ~bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign at_first     = (col == '0) && (row == '0);
  assign at_last_col  = (col == CW'(IMG_W - 1));
  assign at_last      = at_last_col && (row == RW'(IMG_H - 1));
  assign bidx         = BW'(col >> 1);

  // Horizontal pair, then vertical combine with the pair stored on the even row.
  always_comb begin
    pair = '0;
    bufv = linebuf[bidx];
    sum  = '0;
    res  = '0;
    case (mode_q)
      2'd0: pair = {1'b0, (p0 > bus.in_pix) ? p0 : bus.in_pix};
      2'd1: pair = {1'b0, (p0 < bus.in_pix) ? p0 : bus.in_pix};
      2'd2: pair = {1'b0, p0} + {1'b0, bus.in_pix};
      default: pair = {1'b0, p0};
    endcase
    case (mode_q)
      2'd0: res = (bufv > pair) ? bufv[PIX_W-1:0] : pair[PIX_W-1:0];
      2'd1: res = (bufv < pair) ? bufv[PIX_W-1:0] : pair[PIX_W-1:0];
      2'd2: begin
        sum = {1'b0, bufv} + {1'b0, pair} + (PIX_W+2)'(2);
        res = sum[PIX_W+1:2];
      end
      default: res = bufv[PIX_W-1:0];
    endcase
  end

  // Line buffer holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0])
      linebuf[bidx] <= pair;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col           <= '0;
      row           <= '0;
      mode_q        <= 2'd0;
      p0            <= '0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_pix   <= '0;
      bus.out_eol   <= 1'b0;
      bus.out_eof   <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready)
        bus.out_valid <= 1'b0;
      if (accept) begin
        if (at_first)
          mode_q <= bus.mode;
        if (!col[0])
          p0 <= bus.in_pix;
        if (at_last_col) begin
          col <= '0;
          row <= at_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        bus.busy <= ~at_last;
        // A later load in the same cycle as a drain wins over the clear above.
        if (row[0] && col[0]) begin
          bus.out_valid <= 1'b1;
          bus.out_pix   <= res;
          bus.out_eol   <= at_last_col;
          bus.out_eof   <= at_last;
        end
      end
    end
  end
endmodule
